// File: rtl/turn_timer_pkg.sv
// turn_timer_pkg: shared state encoding, default constants and load helper for turn_timer_multi.
// Revision: 1.0
`default_nettype none

package turn_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam int DEF_CLK_FREQ     = 50_000_000;
  localparam int DEF_TURN_SECONDS = 10;
  localparam int DEF_WARN_SECONDS = 3;

  // A runtime turn length of zero falls back to the build-time default.
  function automatic int unsigned load_value(input int unsigned turn_len,
                                             input int unsigned turn_seconds);
    return (turn_len == 0) ? turn_seconds : turn_len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-second terminal strobe; holds while disabled.
// Revision: 1.0
`default_nettype none

module tick_prescaler
  import turn_timer_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic terminal
);

  localparam int CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign terminal = (count_q == C_MAX) && en;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = terminal ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/turn_timer_multi.sv
// turn_timer_multi: N-player turn countdown with pause, low-time warning and auto-advance.
// Revision: 1.0
`default_nettype none

module turn_timer_multi
  import turn_timer_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int TURN_SECONDS = DEF_TURN_SECONDS,
  parameter int N_PLAYERS    = 2,
  parameter int WARN_SECONDS = DEF_WARN_SECONDS,
  parameter int SEC_W        = 4,
  localparam int PLAYER_W    = $clog2(N_PLAYERS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                move_done,
  input  logic [SEC_W-1:0]    turn_len,
  output logic [SEC_W-1:0]    time_remaining,
  output logic [PLAYER_W-1:0] active_player,
  output logic                running,
  output logic                paused,
  output logic                warning,
  output logic                tick_1s,
  output logic                timeout
);

  localparam logic [SEC_W-1:0]    C_WARN        = SEC_W'(WARN_SECONDS);
  localparam logic [PLAYER_W-1:0] C_LAST_PLAYER = PLAYER_W'(N_PLAYERS - 1);

  state_t              state_q, state_d;
  logic [SEC_W-1:0]    time_q, time_d;
  logic [PLAYER_W-1:0] player_q, player_d;
  logic                tick_q, tick_d;
  logic                timeout_q, timeout_d;

  logic [SEC_W-1:0]    load_val;
  logic [PLAYER_W-1:0] next_player;
  logic                pre_en;
  logic                pre_clr;
  logic                pre_terminal;

  assign load_val    = SEC_W'(load_value(32'(turn_len), TURN_SECONDS));
  assign next_player = (player_q == C_LAST_PLAYER) ? '0 : player_q + PLAYER_W'(1);

  // Pause outranks move_done, so a paused-edge move must not clear the prescaler.
  assign pre_en  = (state_q == RUN) && !pause;
  assign pre_clr = stop || start || (pre_en && move_done);

  tick_prescaler #(
    .CLK_FREQ (CLK_FREQ)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (pre_en),
    .clr      (pre_clr),
    .terminal (pre_terminal)
  );

  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    player_d  = player_q;
    tick_d    = 1'b0;
    timeout_d = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      time_d   = '0;
      player_d = '0;
    end else if (start) begin
      state_d  = RUN;
      time_d   = load_val;
      player_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (move_done) begin
            time_d   = load_val;
            player_d = next_player;
          end else if (pre_terminal) begin
            tick_d = 1'b1;
            if (time_q > SEC_W'(1)) begin
              time_d = time_q - SEC_W'(1);
            end else begin
              timeout_d = 1'b1;
              time_d    = load_val;
              player_d  = next_player;
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      time_q    <= '0;
      player_q  <= '0;
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      player_q  <= player_d;
      tick_q    <= tick_d;
      timeout_q <= timeout_d;
    end
  end

  assign time_remaining = time_q;
  assign active_player  = player_q;
  assign running        = (state_q == RUN);
  assign paused         = (state_q == PAUSED);
  assign warning        = (running || paused) && (time_q <= C_WARN);
  assign tick_1s        = tick_q;
  assign timeout        = timeout_q;

endmodule

`default_nettype wire
